fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Fetch-stage PC generator and IF/ID prediction register that sits directly upstream of the branch predictor. It drives the predictor's read address and consumes its fetch-stage prediction and decode-stage misprediction redirect. Each cycle it selects the next PC and carries the fetched instruction, together with its prediction metadata, into decode. Decode uses that metadata to resolve the branch and to write back the branch target buffer.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- STAT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- hazard_stall  in  1  hold PC and IF/ID contents.
- instr_f  in  32  instruction read at pc_f (combinational instruction memory).
- branch_pred_sel  in  1  predictor says redirect to branch_pred_target.
- branch_pred_target  in  32  predicted target.
- mispred_sel  in  1  decode-stage misprediction: redirect and flush.
- mispred_correct_target  in  32  corrected PC.
- pc_f  out  32  current fetch PC, wired to the predictor's read_address.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC, used for the decode write_address.
- pc_plus4_d  out  32  IF/ID pc+4.
- pred_taken_d  out  1  instruction was fetched under a taken prediction.
- pred_target_d  out  32  predicted target captured with it.
- valid_d  out  1  IF/ID holds a real instruction; 0 means bubble.
- stat_pred_cnt, stat_mispred_cnt, stat_stall_cnt  out  STAT_W each  statistics counters (see Configuration).

## Operation
- The FSM has two states, BOOT and RUN. Reset enters BOOT.
  - BOOT lasts exactly one cycle: pc_f holds RESET_PC, no IF/ID load, valid_d stays 0. It then goes to RUN unconditionally.
  - RUN persists until reset.
- Next-PC priority in RUN, highest first:
  - mispred_sel: load mispred_correct_target.
  - hazard_stall: hold pc_f.
  - branch_pred_sel: load branch_pred_target.
  - Otherwise: load pc_f + 4, 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
- IF/ID register update in RUN:
  - mispred_sel: flush. valid_d=0, pred_taken_d=0, pred_target_d=0, instr_d=32'h0 (NOP). pc_d and pc_plus4_d are cleared to 0.
  - Else hazard_stall: all IF/ID fields hold.
  - Else load: instr_d=instr_f, pc_d=pc_f, pc_plus4_d=pc_f+4, pred_taken_d=branch_pred_sel, pred_target_d = branch_pred_sel ? branch_pred_target : 0, valid_d=1.
- mispred_sel together with hazard_stall: the flush and redirect win, and the stall is ignored for this block.
- mispred_sel together with branch_pred_sel: the prediction is discarded and not counted.
- Reset mid-operation (rst_n low at an edge) overrides everything: state, PC and IF/ID return to reset values at that edge.

## Timing
- Reset values: pc_f=RESET_PC; instr_d, pc_d, pc_plus4_d, pred_target_d all 0; pred_taken_d=0; valid_d=0; all counters 0; state BOOT.
- pc_f is registered.
- The predictor output responding to pc_f is combinational in the same cycle and is sampled at the next edge. Redirect latency is therefore 1 cycle, with no fetch bubble on a correct taken prediction.
- A misprediction costs one bubble: the instruction in fetch during the mispred_sel cycle is squashed, and the corrected PC appears in pc_f the following cycle.
- The first valid_d=1 appears 2 edges after rst_n deasserts: BOOT, then the RUN load.

## Configuration
- FETCH_STATS_EN defined: three saturating STAT_W-bit counters, each incrementing once per RUN cycle at the edge.
  - stat_pred_cnt: branch_pred_sel & ~hazard_stall & ~mispred_sel.
  - stat_mispred_cnt: mispred_sel.
  - stat_stall_cnt: hazard_stall & ~mispred_sel.
  - Each counter holds at all-ones. Counters are cleared by reset only.
- FETCH_STATS_EN undefined: the counters are not built, and the three stat outputs are tied to constant 0. All other behaviour is identical.

## Test plan
- Reset release with RESET_PC=32'h100 and no predictions -> pc_f 0x100, 0x100, 0x104, 0x108. valid_d first rises with pc_d=0x100 on the 2nd edge after release.
- branch_pred_sel=1 with target 0x200 at pc_f=0x108 -> next pc_f=0x200. IF/ID holds pc_d=0x108, pred_taken_d=1, pred_target_d=0x200.
- hazard_stall=1 for 3 cycles at pc_f=0x200 -> pc_f and all IF/ID outputs unchanged. stat_stall_cnt increases by 3 (FETCH_STATS_EN).
- mispred_sel=1 with target 0x10C, simultaneous with hazard_stall=1 and branch_pred_sel=1 -> pc_f=0x10C, valid_d=0 and instr_d=0 next cycle. stat_mispred_cnt increases by 1 and stat_pred_cnt is unchanged.
- pc_f=32'hFFFF_FFFC with no redirect -> pc_f=0 next cycle, pc_plus4_d=0.
- rst_n low for one edge mid-stream with valid_d=1 -> every output at its reset value on that edge. Without FETCH_STATS_EN, the stat outputs read 0 throughout.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator and IF/ID register holding prediction metadata for decode.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hazard_stall,
    input  logic [31:0]       instr_f,
    input  logic              branch_pred_sel,
    input  logic [31:0]       branch_pred_target,
    input  logic              mispred_sel,
    input  logic [31:0]       mispred_correct_target,
    output logic [31:0]       pc_f,
    output logic [31:0]       instr_d,
    output logic [31:0]       pc_d,
    output logic [31:0]       pc_plus4_d,
    output logic              pred_taken_d,
    output logic [31:0]       pred_target_d,
    output logic              valid_d,
    output logic [STAT_W-1:0] stat_pred_cnt,
    output logic [STAT_W-1:0] stat_mispred_cnt,
    output logic [STAT_W-1:0] stat_stall_cnt
);

    typedef enum logic {BOOT, RUN} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] pred_target;
        logic        pred_taken;
        logic        valid;
    } ifid_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_n, pc_inc;
    ifid_t       ifid_q, ifid_n;
    logic        run;

    assign pc_inc = pc_q + 32'd4;
    assign run    = (state_q == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ifid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_n;
            ifid_q  <= ifid_n;
        end
    end

    // Misprediction outranks stall so the flush is never delayed behind a hazard.
    always_comb begin
        state_d = RUN;
        pc_n    = pc_q;
        ifid_n  = ifid_q;
        if (run) begin
            if (mispred_sel) begin
                pc_n   = mispred_correct_target;
                ifid_n = '0;
            end else if (!hazard_stall) begin
                pc_n               = branch_pred_sel ? branch_pred_target : pc_inc;
                ifid_n.instr       = instr_f;
                ifid_n.pc          = pc_q;
                ifid_n.pc_plus4    = pc_inc;
                ifid_n.pred_taken  = branch_pred_sel;
                ifid_n.pred_target = branch_pred_sel ? branch_pred_target : 32'h0;
                ifid_n.valid       = 1'b1;
            end
        end
    end

    assign pc_f          = pc_q;
    assign instr_d       = ifid_q.instr;
    assign pc_d          = ifid_q.pc;
    assign pc_plus4_d    = ifid_q.pc_plus4;
    assign pred_taken_d  = ifid_q.pred_taken;
    assign pred_target_d = ifid_q.pred_target;
    assign valid_d       = ifid_q.valid;

`ifdef FETCH_STATS_EN
    logic              inc_pred, inc_mispred, inc_stall;
    logic [STAT_W-1:0] pred_cnt_q, mispred_cnt_q, stall_cnt_q;

    assign inc_pred    = run & branch_pred_sel & ~hazard_stall & ~mispred_sel;
    assign inc_mispred = run & mispred_sel;
    assign inc_stall   = run & hazard_stall & ~mispred_sel;

    // Saturating: each counter sticks at all-ones until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_cnt_q    <= '0;
            mispred_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            if (inc_pred && !(&pred_cnt_q))       pred_cnt_q    <= pred_cnt_q + STAT_W'(1);
            if (inc_mispred && !(&mispred_cnt_q)) mispred_cnt_q <= mispred_cnt_q + STAT_W'(1);
            if (inc_stall && !(&stall_cnt_q))     stall_cnt_q   <= stall_cnt_q + STAT_W'(1);
        end
    end

    assign stat_pred_cnt    = pred_cnt_q;
    assign stat_mispred_cnt = mispred_cnt_q;
    assign stat_stall_cnt   = stall_cnt_q;
`else
    assign stat_pred_cnt    = '0;
    assign stat_mispred_cnt = '0;
    assign stat_stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; stat expectations follow FETCH_STATS_EN.
module tb_fetch_pc_unit;

    localparam int STAT_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hazard_stall;
    logic [31:0]       instr_f;
    logic              branch_pred_sel;
    logic [31:0]       branch_pred_target;
    logic              mispred_sel;
    logic [31:0]       mispred_correct_target;
    logic [31:0]       pc_f, instr_d, pc_d, pc_plus4_d, pred_target_d;
    logic              pred_taken_d, valid_d;
    logic [STAT_W-1:0] stat_pred_cnt, stat_mispred_cnt, stat_stall_cnt;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit #(.RESET_PC(32'h100), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst_n(rst_n), .hazard_stall(hazard_stall), .instr_f(instr_f),
        .branch_pred_sel(branch_pred_sel), .branch_pred_target(branch_pred_target),
        .mispred_sel(mispred_sel), .mispred_correct_target(mispred_correct_target),
        .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .pred_taken_d(pred_taken_d), .pred_target_d(pred_target_d), .valid_d(valid_d),
        .stat_pred_cnt(stat_pred_cnt), .stat_mispred_cnt(stat_mispred_cnt),
        .stat_stall_cnt(stat_stall_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory model: tag the fetch address so instr_d reveals its origin.
    assign instr_f = {16'hA5A5, pc_f[15:0]};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pcd, input logic [31:0] e_p4,
                             input logic e_pt, input logic [31:0] e_ptgt, input logic e_v);
        chk({tag, ".pc_f"}, pc_f, e_pc);
        chk({tag, ".instr_d"}, instr_d, e_instr);
        chk({tag, ".pc_d"}, pc_d, e_pcd);
        chk({tag, ".pc_plus4_d"}, pc_plus4_d, e_p4);
        chk({tag, ".pred_taken_d"}, {31'h0, pred_taken_d}, {31'h0, e_pt});
        chk({tag, ".pred_target_d"}, pred_target_d, e_ptgt);
        chk({tag, ".valid_d"}, {31'h0, valid_d}, {31'h0, e_v});
    endtask

    task automatic chk_stats(input string tag, input int e_pred, input int e_mis, input int e_stall);
`ifdef FETCH_STATS_EN
        chk({tag, ".stat_pred"}, 32'(stat_pred_cnt), 32'(e_pred));
        chk({tag, ".stat_mispred"}, 32'(stat_mispred_cnt), 32'(e_mis));
        chk({tag, ".stat_stall"}, 32'(stat_stall_cnt), 32'(e_stall));
`else
        chk({tag, ".stat_pred"}, 32'(stat_pred_cnt), 32'h0);
        chk({tag, ".stat_mispred"}, 32'(stat_mispred_cnt), 32'h0);
        chk({tag, ".stat_stall"}, 32'(stat_stall_cnt), 32'h0);
        if (e_pred + e_mis + e_stall < 0) $display("unreachable");
`endif
    endtask

    initial begin
        rst_n = 1'b0; hazard_stall = 1'b0; branch_pred_sel = 1'b0; mispred_sel = 1'b0;
        branch_pred_target = 32'h0; mispred_correct_target = 32'h0;
        step(); step();
        chk_state("reset", 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk_stats("reset", 0, 0, 0);

        // BOOT, then first RUN load
        rst_n = 1'b1;
        step();
        chk_state("boot", 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        chk_state("run1", 32'h104, 32'hA5A50100, 32'h100, 32'h104, 1'b0, 32'h0, 1'b1);
        step();
        chk_state("run2", 32'h108, 32'hA5A50104, 32'h104, 32'h108, 1'b0, 32'h0, 1'b1);

        // taken prediction, no bubble
        branch_pred_sel = 1'b1; branch_pred_target = 32'h200;
        step();
        chk_state("pred", 32'h200, 32'hA5A50108, 32'h108, 32'h10C, 1'b1, 32'h200, 1'b1);
        chk_stats("pred", 1, 0, 0);

        // stall with a prediction present: nothing moves, prediction not counted
        hazard_stall = 1'b1; branch_pred_target = 32'h300;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_state("stall", 32'h200, 32'hA5A50108, 32'h108, 32'h10C, 1'b1, 32'h200, 1'b1);
            chk_stats("stall", 1, 0, i);
        end

        // mispredict with stall and prediction: flush + redirect win
        mispred_sel = 1'b1; mispred_correct_target = 32'h10C;
        step();
        chk_state("mispred", 32'h10C, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk_stats("mispred", 1, 1, 3);

        mispred_sel = 1'b0; hazard_stall = 1'b0; branch_pred_sel = 1'b0;
        step();
        chk_state("refetch", 32'h110, 32'hA5A5010C, 32'h10C, 32'h110, 1'b0, 32'h0, 1'b1);

        // one more stall: 2-bit stall counter saturates at 3
        hazard_stall = 1'b1;
        step();
        chk_state("stall_sat", 32'h110, 32'hA5A5010C, 32'h10C, 32'h110, 1'b0, 32'h0, 1'b1);
        chk_stats("stall_sat", 1, 1, 3);

        // redirect to top of address space, then wrap
        hazard_stall = 1'b0; mispred_sel = 1'b1; mispred_correct_target = 32'hFFFF_FFFC;
        step();
        chk_state("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        mispred_sel = 1'b0;
        step();
        chk_state("wrap", 32'h0, 32'hA5A5FFFC, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, 1'b1);
        step();
        chk_state("post_wrap", 32'h4, 32'hA5A50000, 32'h0, 32'h4, 1'b0, 32'h0, 1'b1);

        branch_pred_sel = 1'b1; branch_pred_target = 32'h40;
        step();
        chk_state("pred2", 32'h40, 32'hA5A50004, 32'h4, 32'h8, 1'b1, 32'h40, 1'b1);
        chk_stats("pred2", 2, 2, 3);

        // reset mid-stream overrides a live prediction
        rst_n = 1'b0;
        step();
        chk_state("midreset", 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk_stats("midreset", 0, 0, 0);

        // BOOT ignores the predictor
        rst_n = 1'b1;
        step();
        chk_state("reboot", 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk_stats("reboot", 0, 0, 0);
        branch_pred_sel = 1'b0;
        step();
        chk_state("rerun", 32'h104, 32'hA5A50100, 32'h100, 32'h104, 1'b0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
